ibex_mem_responder: RTL and testbench
=====================================

Name: ibex_mem_responder

Overview:
Memory-side responder for the Ibex instruction/data bus protocol (req/gnt/rvalid, in-order responses). It holds a word-addressed SRAM model and answers requests from one core port (instr or data) with programmable grant delay, response latency and outstanding-request limit. It is instanced once per core port in core-level simulation and formal harnesses.

Parameters:
Depth, 1024, number of 32-bit words; power of two, >=2
BaseAddr, 32'h0000_0000, byte address of word 0; Depth*4-aligned
GntDelay, 0, request cycles before gnt_o may assert (0 = same cycle)
RspLatency, 1, cycles from grant edge to rvalid_o; >=1
MaxOutstanding, 2, max granted-but-unanswered requests; 1..RspLatency

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  request valid, held by initiator until gnt_o
gnt_o  out  1  request accepted this cycle
addr_i  in  32  byte address, valid while req_i
we_i  in  1  1 = write, 0 = read
be_i  in  4  byte enables
wdata_i  in  32  write data
rvalid_o  out  1  response valid, exactly one cycle per granted request
rdata_o  out  32  read data, valid with rvalid_o
err_o  out  1  bus error, valid with rvalid_o
outstanding_o  out  $clog2(MaxOutstanding+1)  in-flight request count

Behaviour:
- Reset (async assert, sync release): rvalid_o=0, rdata_o=0, err_o=0, outstanding_o=0, wait counter=0, response pipeline cleared. gnt_o=0 while rst_ni=0. Memory array not reset.
- Reset mid-operation: all in-flight responses are dropped; no rvalid_o after reset release for pre-reset grants.
- Address decode: off = addr_i - BaseAddr (32-bit, wrapping). In range iff off < Depth*4. Index = off[$clog2(Depth)+1:2]. addr_i[1:0] ignored.
- Wait counter: increments each cycle req_i=1 && gnt_o=0, saturating at GntDelay. Clears when gnt_o=1 or req_i=0.
- gnt_o (combinational) = req_i && (wait==GntDelay) && !full && !stall. GntDelay=0 -> same-cycle grant.
- full = (outstanding == MaxOutstanding) && !retire, where retire = rvalid_o asserted this cycle. Grant and retire in the same cycle -> count unchanged.
- Handshake: request accepted at the rising edge where req_i && gnt_o. At that edge:
  - in-range write: bytes with be_i[k]=1 take wdata_i[8k+7:8k]; others unchanged; be_i=0 writes nothing and is not an error.
  - in-range read: mem[index] is captured into the response pipeline (be_i ignored, full word returned).
  - out of range: no memory access; response err=1, rdata=0.
- Response: rvalid_o=1 exactly RspLatency cycles after the grant edge (RspLatency=1 -> cycle after grant). Responses are strictly in grant order, one per cycle max. Writes respond with rdata_o=0, err_o=0 (unless out of range).
- rdata_o/err_o are forced to 0 in cycles with rvalid_o=0.
- Read-after-write: a read granted on any cycle after a write's grant returns the written data, even if the write response is still in flight.
- outstanding_o: +1 on grant, -1 on rvalid_o, net 0 when both occur; never exceeds MaxOutstanding.
- req_i dropped before gnt_o (protocol violation): counter clears, no state change, no response.

Optional Feature:
IBEX_MEM_RESP_RANDSTALL_EN: when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances every cycle and stall = lfsr[0]. While stall=1, gnt_o is held at 0 and the wait counter holds its value. When undefined, stall is tied 0 and gnt timing is fully deterministic per GntDelay/MaxOutstanding.

Test Plan:
- Write/read: write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 -> rvalid_o one cycle after each grant, read rdata_o=0xDEADBEEF, err_o=0.
- Byte enables: mem[0x20]=0x11223344, write 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- Out of range (Depth=1024, BaseAddr=0): read 0x1000 -> err_o=1, rdata_o=0; write 0x1000 leaves mem unchanged; BaseAddr=0x8000, read 0x7FFC -> err_o=1.
- GntDelay=2: req_i held from cycle 0 -> gnt_o in cycle 2 only; back-to-back requests each wait 2 cycles.
- Outstanding limit (RspLatency=3, MaxOutstanding=2): req_i held continuously -> grants in cycles 0,1, none in 2, grant in 3 coincident with first rvalid_o; outstanding_o never >2.
- Reset mid-op: assert rst_ni=0 one cycle after a read grant with RspLatency=3 -> no rvalid_o after release; outstanding_o=0.

Source files
------------

// File: rtl/ibex_mem_responder.sv
// ibex_mem_responder: memory-side responder for the Ibex req/gnt/rvalid bus.
// It holds a word-addressed SRAM model and answers one core port.
// The grant delay, response latency and outstanding-request limit are set by parameters.
// Optional build macro: IBEX_MEM_RESP_RANDSTALL_EN adds LFSR-driven random grant stalls.
module ibex_mem_responder #(
  parameter int unsigned Depth          = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned GntDelay       = 0,
  parameter int unsigned RspLatency     = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  req_i,
  output logic                                  gnt_o,
  input  logic [31:0]                           addr_i,
  input  logic                                  we_i,
  input  logic [3:0]                            be_i,
  input  logic [31:0]                           wdata_i,
  output logic                                  rvalid_o,
  output logic [31:0]                           rdata_o,
  output logic                                  err_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

  localparam int unsigned IdxW     = $clog2(Depth);
  localparam int unsigned WaitW    = (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
  localparam int unsigned OutW     = $clog2(MaxOutstanding + 1);
  localparam logic [32:0] MemBytes = 33'(Depth) * 33'd4;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(GntDelay);
  localparam logic [OutW-1:0]  OutMax  = OutW'(MaxOutstanding);

  // Storage array, deliberately left out of reset like a real SRAM
  logic [31:0] mem_q [Depth];

  // Address decode results
  logic [31:0]     offset;
  logic            inRange;
  logic [IdxW-1:0] wordIdx;

  // Grant-delay wait counter
  logic [WaitW-1:0] waitCnt_q, waitCnt_d;

  // Count of granted requests whose response has not yet been presented
  logic [OutW-1:0] outCnt_q, outCnt_d;

  // Response pipeline; stage 0 is loaded at the grant edge and the last stage drives the outputs
  logic [RspLatency-1:0] pipeValid_q;
  logic [RspLatency-1:0] pipeErr_q;
  logic [31:0]           pipeData_q [RspLatency];

  logic stall;
  logic full;
  logic retire;
  logic grant;

  // Offset arithmetic wraps, so addresses below BaseAddr become huge offsets and decode as out of range
  assign offset  = addr_i - BaseAddr;
  assign inRange = ({1'b0, offset} < MemBytes);
  assign wordIdx = offset[IdxW+1:2];

`ifdef IBEX_MEM_RESP_RANDSTALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR (taps 16,14,13,11) that advances every cycle; its LSB vetoes grants
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // A response leaving the pipeline frees its slot in the same cycle, so grant and retire can overlap
  assign retire = pipeValid_q[RspLatency-1];
  assign full   = (outCnt_q == OutMax) && !retire;
  assign grant  = rst_ni && req_i && (waitCnt_q == WaitMax) && !full && !stall;
  assign gnt_o  = grant;

  // The wait counter counts unanswered request cycles up to GntDelay; it holds during a stall and clears otherwise
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (!req_i || grant) begin
      waitCnt_d = '0;
    end else if (!stall && (waitCnt_q != WaitMax)) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  // In-flight count moves up on grant, down on retire, and stays put when both happen together
  always_comb begin
    outCnt_d = outCnt_q;
    case ({grant, retire})
      2'b10:   outCnt_d = outCnt_q + 1'b1;
      2'b01:   outCnt_d = outCnt_q - 1'b1;
      default: outCnt_d = outCnt_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waitCnt_q <= '0;
      outCnt_q  <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
      outCnt_q  <= outCnt_d;
    end
  end

  // Byte-masked write on an accepted in-range write; later reads see the data even before this write is answered
  always_ff @(posedge clk_i) begin
    if (grant && we_i && inRange) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem_q[wordIdx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Response pipeline: capture read data or the error flag at the grant edge, then shift toward the outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipeValid_q <= '0;
      pipeErr_q   <= '0;
      for (int i = 0; i < RspLatency; i++) begin
        pipeData_q[i] <= '0;
      end
    end else begin
      for (int i = RspLatency - 1; i > 0; i--) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeErr_q[i]   <= pipeErr_q[i-1];
        pipeData_q[i]  <= pipeData_q[i-1];
      end
      pipeValid_q[0] <= grant;
      pipeErr_q[0]   <= grant && !inRange;
      pipeData_q[0]  <= (grant && !we_i && inRange) ? mem_q[wordIdx] : 32'h0;
    end
  end

  // Outputs are masked to zero whenever no response is presented
  assign rvalid_o      = pipeValid_q[RspLatency-1];
  assign err_o         = rvalid_o && pipeErr_q[RspLatency-1];
  assign rdata_o       = rvalid_o ? pipeData_q[RspLatency-1] : 32'h0;
  assign outstanding_o = outCnt_q;

  // Protocol sanity properties
  assert property (@(posedge clk_i) disable iff (!rst_ni) outCnt_q <= OutMax);
  assert property (@(posedge clk_i) disable iff (!rst_ni) gnt_o |-> req_i);

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Testbench for ibex_mem_responder.
// A driver issues directed and random requests and pushes the expected responses into a scoreboard.
// A monitor checks grant timing, the in-flight count, and response data against a reference model.
module tb_ibex_mem_responder;

  localparam int unsigned Depth          = 64;
  localparam logic [31:0] BaseAddr       = 32'h0000_8000;
  localparam int unsigned GntDelay       = 1;
  localparam int unsigned RspLatency     = 5;
  localparam int unsigned MaxOutstanding = 2;
  localparam int unsigned OutW           = $clog2(MaxOutstanding + 1);

  logic            clk_i   = 1'b0;
  logic            rst_ni  = 1'b1;
  logic            req_i   = 1'b0;
  logic            we_i    = 1'b0;
  logic [31:0]     addr_i  = '0;
  logic [3:0]      be_i    = '0;
  logic [31:0]     wdata_i = '0;
  logic            gnt_o;
  logic            rvalid_o;
  logic [31:0]     rdata_o;
  logic            err_o;
  logic [OutW-1:0] outstanding_o;

  always #5 clk_i = ~clk_i;

  ibex_mem_responder #(
    .Depth(Depth),
    .BaseAddr(BaseAddr),
    .GntDelay(GntDelay),
    .RspLatency(RspLatency),
    .MaxOutstanding(MaxOutstanding)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_i(req_i),
    .gnt_o(gnt_o),
    .addr_i(addr_i),
    .we_i(we_i),
    .be_i(be_i),
    .wdata_i(wdata_i),
    .rvalid_o(rvalid_o),
    .rdata_o(rdata_o),
    .err_o(err_o),
    .outstanding_o(outstanding_o)
  );

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  int          cyc        = 0;
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] modelMem [Depth];
  rsp_t        expQ [$];
  int          dueQ [$];
  int          age = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, wanted 0x%08h", name, cyc, act, exp);
    end
  endtask

  // The reference model gives the expected response of an accepted request and applies writes to the model memory
  task automatic recordGrant(input bit we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata);
    logic [31:0] off;
    int unsigned idx;
    rsp_t        r;
    off    = addr - BaseAddr;
    idx    = off / 4;
    r.err  = 1'b0;
    r.data = 32'h0;
    if (off >= Depth * 4) begin
      r.err = 1'b1;
    end else if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) modelMem[idx][8*k +: 8] = wdata[8*k +: 8];
      end
    end else begin
      r.data = modelMem[idx];
    end
    expQ.push_back(r);
  endtask

  task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input bit keepReq);
    int waited;
    bit done;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    be_i    = be;
    wdata_i = wdata;
    waited  = 0;
    done    = 0;
    while (!done) begin
      @(negedge clk_i);
      if (gnt_o) begin
        recordGrant(we, addr, be, wdata);
        done = 1;
      end else if (waited >= 50) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL grant_timeout: no gnt_o after %0d cycles for addr 0x%08h, wanted a grant", waited, addr);
        done = 1;
      end
      waited++;
      @(posedge clk_i);
      #1;
    end
    if (!keepReq) req_i = 1'b0;
  endtask

  // A request that is withdrawn before it can be granted; it must leave no trace
  task automatic applyAbort(input logic [31:0] addr);
    req_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = addr;
    be_i   = 4'hF;
    wdata_i = 32'h0BAD_0BAD;
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic doReset();
    req_i  = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Monitor: model grant timing from waited cycles and in-flight due times, then compare every cycle
  always @(negedge clk_i) begin : monitor
    bit   expRvalid;
    bit   expFull;
    bit   expGnt;
    int   expOut;
    rsp_t got;
    if (!rst_ni) begin
      checkOutput("reset_gnt", {31'h0, gnt_o}, 32'h0);
      checkOutput("reset_rvalid", {31'h0, rvalid_o}, 32'h0);
      checkOutput("reset_outstanding", 32'(outstanding_o), 32'h0);
      checkOutput("reset_rdata", rdata_o, 32'h0);
      dueQ.delete();
      expQ.delete();
      age = 0;
    end else begin
      expRvalid = (dueQ.size() > 0) && (dueQ[0] == cyc);
      expOut    = dueQ.size();
      expFull   = (expOut == MaxOutstanding) && !expRvalid;
      expGnt    = req_i && (age >= GntDelay) && !expFull;
      checkOutput("gnt", {31'h0, gnt_o}, {31'h0, expGnt});
      checkOutput("outstanding", 32'(outstanding_o), 32'(expOut));
      checkOutput("rvalid", {31'h0, rvalid_o}, {31'h0, expRvalid});
      if (rvalid_o) begin
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL spurious_rvalid at cycle %0d: got rvalid with rdata 0x%08h, wanted no response", cyc, rdata_o);
        end else begin
          got = expQ.pop_front();
          checkOutput("rdata", rdata_o, got.data);
          checkOutput("err", {31'h0, err_o}, {31'h0, got.err});
        end
      end else begin
        checkOutput("idle_rdata", rdata_o, 32'h0);
        checkOutput("idle_err", {31'h0, err_o}, 32'h0);
      end
      if (expRvalid) void'(dueQ.pop_front());
      if (expGnt) dueQ.push_back(cyc + RspLatency);
      age = (req_i && !expGnt) ? age + 1 : 0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, wanted completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    $display("[TB] filling memory");
    for (int i = 0; i < Depth; i++) begin
      applyStimulus(1'b1, BaseAddr + 32'(i) * 4, 4'hF, $urandom, 1'b1);
    end
    req_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("[TB] directed write/read and byte enables");
    applyStimulus(1'b1, BaseAddr + 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(1'b0, BaseAddr + 32'h10, 4'hF, 32'h0, 1'b0);
    applyStimulus(1'b1, BaseAddr + 32'h20, 4'hF, 32'h1122_3344, 1'b0);
    applyStimulus(1'b1, BaseAddr + 32'h20, 4'b0101, 32'hAABB_CCDD, 1'b0);
    applyStimulus(1'b0, BaseAddr + 32'h23, 4'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, BaseAddr + 32'h24, 4'h0, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, BaseAddr + 32'h24, 4'hF, 32'h0, 1'b0);

    $display("[TB] directed out-of-range accesses");
    applyStimulus(1'b0, BaseAddr - 32'h4, 4'hF, 32'h0, 1'b0);
    applyStimulus(1'b0, BaseAddr + Depth * 4, 4'hF, 32'h0, 1'b0);
    applyStimulus(1'b1, BaseAddr + Depth * 4, 4'hF, 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b0, BaseAddr, 4'hF, 32'h0, 1'b0);
    applyStimulus(1'b1, BaseAddr - 32'h4, 4'hF, 32'h5555_AAAA, 1'b0);
    applyStimulus(1'b0, BaseAddr + Depth * 4 - 4, 4'hF, 32'h0, 1'b0);

    $display("[TB] back-to-back read-after-write and an aborted request");
    applyStimulus(1'b1, BaseAddr + 32'h30, 4'hF, 32'h1234_5678, 1'b1);
    applyStimulus(1'b0, BaseAddr + 32'h30, 4'hF, 32'h0, 1'b0);
    @(posedge clk_i);
    #1;
    applyAbort(BaseAddr + 32'h34);
    applyStimulus(1'b0, BaseAddr + 32'h34, 4'hF, 32'h0, 1'b0);

    $display("[TB] reset during an in-flight read");
    repeat (RspLatency + 1) @(posedge clk_i);
    #1;
    applyStimulus(1'b0, BaseAddr + 32'h8, 4'hF, 32'h0, 1'b0);
    doReset();
    repeat (RspLatency + 3) @(posedge clk_i);
    #1;

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      bit          w;
      bit          keep;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      keep = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) a = BaseAddr + $urandom_range(0, Depth - 1) * 4 + $urandom_range(0, 3);
      else a = $urandom;
      applyStimulus(w, a, 4'($urandom), $urandom, keep);
      if (!keep) begin
        repeat ($urandom_range(0, 2)) @(posedge clk_i);
        #1;
      end
    end
    req_i = 1'b0;
    repeat (RspLatency + 3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("drain_pending", 32'(expQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
